// File: rtl/map_access_arbiter.sv
// map_access_arbiter: shares the single-port map RAM between the display
// controller (read-only), the pacman logic and the ghost logic. Requesters
// use a request/acknowledge handshake. Only one access is outstanding at a
// time, and every output is registered.
// Optional build macro MAP_ARB_RR_EN: the display keeps absolute priority,
// and pacman/ghost ties go to whichever of the two was served less recently.
module map_access_arbiter #(
   parameter int MAP_W      = 5,
   parameter int DATA_W     = 3,
   parameter int RD_LATENCY = 1
) (
   input  logic              clock_50,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [MAP_W-1:0]  disp_x,
   input  logic [MAP_W-1:0]  disp_y,
   output logic              disp_ack,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              pac_req,
   input  logic              pac_we,
   input  logic [MAP_W-1:0]  pac_x,
   input  logic [MAP_W-1:0]  pac_y,
   input  logic [DATA_W-1:0] pac_wdata,
   output logic              pac_ack,
   output logic [DATA_W-1:0] pac_rdata,
   input  logic              ghost_req,
   input  logic              ghost_we,
   input  logic [MAP_W-1:0]  ghost_x,
   input  logic [MAP_W-1:0]  ghost_y,
   input  logic [DATA_W-1:0] ghost_wdata,
   output logic              ghost_ack,
   output logic [DATA_W-1:0] ghost_rdata,
   output logic [MAP_W-1:0]  map_x,
   output logic [MAP_W-1:0]  map_y,
   output logic [DATA_W-1:0] map_data_in,
   output logic              map_readwrite,
   input  logic [DATA_W-1:0] map_data_out,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [1:0] ID_DISP  = 2'd0;
   localparam logic [1:0] ID_PAC   = 2'd1;
   localparam logic [1:0] ID_GHOST = 2'd2;
   localparam logic [1:0] LAT      = 2'(RD_LATENCY);

   state_t              state_q, state_d;
   logic [1:0]          id_q, id_d;
   logic                we_q, we_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [MAP_W-1:0]    map_x_q, map_x_d, map_y_q, map_y_d;
   logic [DATA_W-1:0]   map_data_in_q, map_data_in_d;
   logic                map_readwrite_q, map_readwrite_d;
   logic                busy_q, busy_d;
   logic                disp_ack_q, disp_ack_d, pac_ack_q, pac_ack_d, ghost_ack_q, ghost_ack_d;
   logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d, pac_rdata_q, pac_rdata_d;
   logic [DATA_W-1:0]   ghost_rdata_q, ghost_rdata_d;
   logic [1:0]          win_id;
   logic                any_req;
`ifdef MAP_ARB_RR_EN
   logic                last_ghost_q, last_ghost_d;
`endif

   // Pick the winner among the requests presented in this cycle.
   always_comb begin
      win_id  = ID_DISP;
      any_req = disp_req | pac_req | ghost_req;
      if (disp_req) begin
         win_id = ID_DISP;
      end else if (pac_req && ghost_req) begin
`ifdef MAP_ARB_RR_EN
         win_id = last_ghost_q ? ID_PAC : ID_GHOST;
`else
         win_id = ID_PAC;
`endif
      end else if (pac_req) begin
         win_id = ID_PAC;
      end else begin
         win_id = ID_GHOST;
      end
   end

   // Next-state and registered-output logic of the access FSM.
   always_comb begin
      state_d         = state_q;
      id_d            = id_q;
      we_d            = we_q;
      cnt_d           = cnt_q;
      map_x_d         = map_x_q;
      map_y_d         = map_y_q;
      map_data_in_d   = map_data_in_q;
      map_readwrite_d = map_readwrite_q;
      busy_d          = busy_q;
      disp_ack_d      = 1'b0;
      pac_ack_d       = 1'b0;
      ghost_ack_d     = 1'b0;
      disp_rdata_d    = disp_rdata_q;
      pac_rdata_d     = pac_rdata_q;
      ghost_rdata_d   = ghost_rdata_q;
`ifdef MAP_ARB_RR_EN
      last_ghost_d    = last_ghost_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               id_d    = win_id;
               busy_d  = 1'b1;
               state_d = ISSUE;
               case (win_id)
                  ID_PAC: begin
                     map_x_d         = pac_x;
                     map_y_d         = pac_y;
                     we_d            = pac_we;
                     map_readwrite_d = pac_we;
                     map_data_in_d   = pac_wdata;
                  end
                  ID_GHOST: begin
                     map_x_d         = ghost_x;
                     map_y_d         = ghost_y;
                     we_d            = ghost_we;
                     map_readwrite_d = ghost_we;
                     map_data_in_d   = ghost_wdata;
                  end
                  default: begin
                     map_x_d         = disp_x;
                     map_y_d         = disp_y;
                     we_d            = 1'b0;
                     map_readwrite_d = 1'b0;
                  end
               endcase
`ifdef MAP_ARB_RR_EN
               if (win_id != ID_DISP) last_ghost_d = (win_id == ID_GHOST);
`endif
            end
         end
         ISSUE: begin
            // The write strobe lasts exactly the one ISSUE cycle.
            map_readwrite_d = 1'b0;
            cnt_d           = LAT;
            state_d         = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
               if (!we_q) begin
                  case (id_q)
                     ID_PAC:   pac_rdata_d   = map_data_out;
                     ID_GHOST: ghost_rdata_d = map_data_out;
                     default:  disp_rdata_d  = map_data_out;
                  endcase
               end
               case (id_q)
                  ID_PAC:   pac_ack_d   = 1'b1;
                  ID_GHOST: ghost_ack_d = 1'b1;
                  default:  disp_ack_d  = 1'b1;
               endcase
               state_d = DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access immediately.
   always_ff @(posedge clock_50 or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         id_q            <= ID_DISP;
         we_q            <= 1'b0;
         cnt_q           <= 2'd0;
         map_x_q         <= '0;
         map_y_q         <= '0;
         map_data_in_q   <= '0;
         map_readwrite_q <= 1'b0;
         busy_q          <= 1'b0;
         disp_ack_q      <= 1'b0;
         pac_ack_q       <= 1'b0;
         ghost_ack_q     <= 1'b0;
         disp_rdata_q    <= '0;
         pac_rdata_q     <= '0;
         ghost_rdata_q   <= '0;
`ifdef MAP_ARB_RR_EN
         last_ghost_q    <= 1'b1;
`endif
      end else begin
         state_q         <= state_d;
         id_q            <= id_d;
         we_q            <= we_d;
         cnt_q           <= cnt_d;
         map_x_q         <= map_x_d;
         map_y_q         <= map_y_d;
         map_data_in_q   <= map_data_in_d;
         map_readwrite_q <= map_readwrite_d;
         busy_q          <= busy_d;
         disp_ack_q      <= disp_ack_d;
         pac_ack_q       <= pac_ack_d;
         ghost_ack_q     <= ghost_ack_d;
         disp_rdata_q    <= disp_rdata_d;
         pac_rdata_q     <= pac_rdata_d;
         ghost_rdata_q   <= ghost_rdata_d;
`ifdef MAP_ARB_RR_EN
         last_ghost_q    <= last_ghost_d;
`endif
      end
   end

   assign map_x         = map_x_q;
   assign map_y         = map_y_q;
   assign map_data_in   = map_data_in_q;
   assign map_readwrite = map_readwrite_q;
   assign busy          = busy_q;
   assign disp_ack      = disp_ack_q;
   assign pac_ack       = pac_ack_q;
   assign ghost_ack     = ghost_ack_q;
   assign disp_rdata    = disp_rdata_q;
   assign pac_rdata     = pac_rdata_q;
   assign ghost_rdata   = ghost_rdata_q;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Bench for map_access_arbiter: u_dut runs with RD_LATENCY=1 against a map
// RAM model, u_dut3 runs with RD_LATENCY=3. Expected acks go into queues and
// are popped by a monitor. Unwritten RAM cells read as (x ^ y) & 7.
module tb_map_access_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic ram_init;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       disp_req, disp_ack;
   logic [4:0] disp_x, disp_y;
   logic [2:0] disp_rdata;
   logic       pac_req, pac_we, pac_ack;
   logic [4:0] pac_x, pac_y;
   logic [2:0] pac_wdata, pac_rdata;
   logic       ghost_req, ghost_we, ghost_ack;
   logic [4:0] ghost_x, ghost_y;
   logic [2:0] ghost_wdata, ghost_rdata;
   logic [4:0] map_x, map_y;
   logic [2:0] map_data_in, map_data_out;
   logic       map_readwrite, busy;

   logic       d3_disp_req, d3_disp_ack, d3_pac_ack, d3_ghost_ack;
   logic [4:0] d3_disp_x, d3_disp_y, d3_map_x, d3_map_y;
   logic [2:0] d3_disp_rdata, d3_pac_rdata, d3_ghost_rdata, d3_map_data_in, d3_map_data_out;
   logic       d3_map_readwrite, d3_busy;

   map_access_arbiter #(.MAP_W(5), .DATA_W(3), .RD_LATENCY(1)) u_dut (
      .clock_50(clk), .reset(reset),
      .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
      .disp_ack(disp_ack), .disp_rdata(disp_rdata),
      .pac_req(pac_req), .pac_we(pac_we), .pac_x(pac_x), .pac_y(pac_y),
      .pac_wdata(pac_wdata), .pac_ack(pac_ack), .pac_rdata(pac_rdata),
      .ghost_req(ghost_req), .ghost_we(ghost_we), .ghost_x(ghost_x), .ghost_y(ghost_y),
      .ghost_wdata(ghost_wdata), .ghost_ack(ghost_ack), .ghost_rdata(ghost_rdata),
      .map_x(map_x), .map_y(map_y), .map_data_in(map_data_in),
      .map_readwrite(map_readwrite), .map_data_out(map_data_out), .busy(busy));

   map_access_arbiter #(.MAP_W(5), .DATA_W(3), .RD_LATENCY(3)) u_dut3 (
      .clock_50(clk), .reset(reset),
      .disp_req(d3_disp_req), .disp_x(d3_disp_x), .disp_y(d3_disp_y),
      .disp_ack(d3_disp_ack), .disp_rdata(d3_disp_rdata),
      .pac_req(1'b0), .pac_we(1'b0), .pac_x(5'd0), .pac_y(5'd0),
      .pac_wdata(3'd0), .pac_ack(d3_pac_ack), .pac_rdata(d3_pac_rdata),
      .ghost_req(1'b0), .ghost_we(1'b0), .ghost_x(5'd0), .ghost_y(5'd0),
      .ghost_wdata(3'd0), .ghost_ack(d3_ghost_ack), .ghost_rdata(d3_ghost_rdata),
      .map_x(d3_map_x), .map_y(d3_map_y), .map_data_in(d3_map_data_in),
      .map_readwrite(d3_map_readwrite), .map_data_out(d3_map_data_out), .busy(d3_busy));

   // Map RAM model, one cycle read latency.
   logic [2:0] mem [32][32];
   logic       wv  [32][32];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) wv[i][j] <= 1'b0;
      end else if (map_readwrite) begin
         mem[map_x][map_y] <= map_data_in;
         wv[map_x][map_y]  <= 1'b1;
      end
      map_data_out <= wv[map_x][map_y] ? mem[map_x][map_y] : (map_x[2:0] ^ map_y[2:0]);
   end

   // Read-only RAM model, three cycle read latency.
   logic [2:0] p1, p2, p3;
   always @(posedge clk) begin
      p1 <= d3_map_x[2:0] ^ d3_map_y[2:0];
      p2 <= p1;
      p3 <= p2;
   end
   assign d3_map_data_out = p3;

   typedef struct {
      int         who;
      int         cyc;
      logic [2:0] rdata;
   } exp_t;
   exp_t q1[$];
   exp_t q3[$];
   int   checks   = 0;
   int   failures = 0;
   int   wr_cnt   = 0;
   int   d3_wr_cnt = 0;

   initial forever begin
      @(negedge clk);
      if (map_readwrite) wr_cnt++;
      if (d3_map_readwrite) d3_wr_cnt++;
   end

   // Scoreboard monitor: pops an expectation for every ack pulse.
   initial forever begin
      int n, who;
      logic [2:0] rd;
      exp_t e;
      @(negedge clk);
      n = int'(disp_ack) + int'(pac_ack) + int'(ghost_ack);
      if (n > 0) begin
         who = disp_ack ? 0 : (pac_ack ? 1 : 2);
         rd  = disp_ack ? disp_rdata : (pac_ack ? pac_rdata : ghost_rdata);
         checks++;
         if (n > 1) begin
            failures++;
            $display("FAIL ack_onehot acks=%0d required=1 cyc=%0d", n, cyc);
         end else if (q1.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack who=%0d cyc=%0d required=none", who, cyc);
         end else begin
            e = q1.pop_front();
            if (who != e.who || cyc != e.cyc || rd != e.rdata) begin
               failures++;
               $display("FAIL sb_ack who=%0d cyc=%0d rdata=%0d required who=%0d cyc=%0d rdata=%0d",
                        who, cyc, rd, e.who, e.cyc, e.rdata);
            end
         end
      end
      if (d3_pac_ack || d3_ghost_ack) begin
         checks++;
         failures++;
         $display("FAIL d3_spurious_ack cyc=%0d required=none", cyc);
      end
      if (d3_disp_ack) begin
         checks++;
         if (q3.size() == 0) begin
            failures++;
            $display("FAIL d3_unexpected_ack cyc=%0d required=none", cyc);
         end else begin
            e = q3.pop_front();
            if (cyc != e.cyc || d3_disp_rdata != e.rdata) begin
               failures++;
               $display("FAIL d3_sb_ack cyc=%0d rdata=%0d required cyc=%0d rdata=%0d",
                        cyc, d3_disp_rdata, e.cyc, e.rdata);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int who, input bit we, input int x, input int y, input int wd);
      case (who)
         0: begin disp_x = 5'(x); disp_y = 5'(y); disp_req = 1'b1; end
         1: begin pac_x = 5'(x); pac_y = 5'(y); pac_we = we; pac_wdata = 3'(wd); pac_req = 1'b1; end
         2: begin ghost_x = 5'(x); ghost_y = 5'(y); ghost_we = we; ghost_wdata = 3'(wd); ghost_req = 1'b1; end
         default: begin d3_disp_x = 5'(x); d3_disp_y = 5'(y); d3_disp_req = 1'b1; end
      endcase
   endtask

   task automatic clr_req(input int who);
      case (who)
         0: disp_req = 1'b0;
         1: pac_req = 1'b0;
         2: ghost_req = 1'b0;
         default: d3_disp_req = 1'b0;
      endcase
   endtask

   task automatic wait_ack(input int who, input int budget);
      bit got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         case (who)
            0: got = disp_ack;
            1: got = pac_ack;
            2: got = ghost_ack;
            default: got = d3_disp_ack;
         endcase
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout who=%0d actual=no_ack required=ack", who);
      end
   endtask

   // Holds its request until the ack, then drops it on the next edge.
   task automatic requester(input int who, input bit we, input int x, input int y, input int wd);
      set_req(who, we, x, y, wd);
      wait_ack(who, 40);
      tick();
      clr_req(who);
   endtask

   initial begin
      int c, w0;
      disp_req = 0; disp_x = 0; disp_y = 0;
      pac_req = 0; pac_we = 0; pac_x = 0; pac_y = 0; pac_wdata = 0;
      ghost_req = 0; ghost_we = 0; ghost_x = 0; ghost_y = 0; ghost_wdata = 0;
      d3_disp_req = 0; d3_disp_x = 0; d3_disp_y = 0;
      ram_init = 1'b1;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we", 32'(map_readwrite), 0);
      chk("rst_acks", 32'({disp_ack, pac_ack, ghost_ack}), 0);
      chk("rst_addr", 32'({map_x, map_y}), 0);
      tick();
      ram_init = 1'b0;
      reset = 1'b1;
      repeat (2) tick();

      // Reset during a pacman write's ISSUE cycle.
      set_req(1, 1'b1, 3, 4, 5);
      tick();
      chk("issue_we", 32'(map_readwrite), 1);
      reset = 1'b0;
      #1;
      chk("abort_we", 32'(map_readwrite), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_addr", 32'({map_x, map_y, map_data_in}), 0);
      clr_req(1);
      #2 reset = 1'b1;
      repeat (4) tick();
      chk("abort_nowrite", 32'(wv[3][4]), 0);
      chk("abort_idle", 32'(busy), 0);

      // Single display read: RAM(2,7) = 2^7 = 5.
      tick();
      c = cyc;
      q1.push_back('{0, c + 3, 3'd5});
      fork
         requester(0, 1'b0, 2, 7, 0);
         begin
            @(negedge clk);
            @(negedge clk);
            chk("rd_map_x", 32'(map_x), 2);
            chk("rd_map_y", 32'(map_y), 7);
            chk("rd_busy1", 32'(busy), 1);
            @(negedge clk);
            chk("rd_busy2", 32'(busy), 1);
            @(negedge clk);
            chk("rd_busy3", 32'(busy), 1);
            @(negedge clk);
            chk("rd_busy4", 32'(busy), 0);
         end
      join

      // Pacman write (10,5)=6, read it back, then overwrite with 1.
      tick();
      c = cyc; w0 = wr_cnt;
      q1.push_back('{1, c + 3, 3'd0});
      requester(1, 1'b1, 10, 5, 6);
      chk("wr_pulse_cycles", wr_cnt - w0, 1);
      chk("wr_mem", 32'(mem[10][5]), 6);
      tick();
      c = cyc;
      q1.push_back('{1, c + 3, 3'd6});
      requester(1, 1'b0, 10, 5, 0);
      tick();
      c = cyc;
      q1.push_back('{1, c + 3, 3'd6});
      requester(1, 1'b1, 10, 5, 1);
      chk("wr2_mem", 32'(mem[10][5]), 1);

      // Reset in IDLE clears the read data registers.
      tick();
      reset = 1'b0;
      #1;
      chk("rst_rdata", 32'(pac_rdata), 0);
      reset = 1'b1;
      tick();

      // Contention: all three request at once.
      tick();
      c = cyc;
      q1.push_back('{0, c + 3, 3'd0});
      q1.push_back('{1, c + 7, 3'd1});
      q1.push_back('{2, c + 11, 3'd0});
      fork
         requester(0, 1'b0, 1, 1, 0);
         requester(1, 1'b0, 10, 5, 0);
         requester(2, 1'b1, 0, 31, 7);
      join
      tick();
      c = cyc;
      q1.push_back('{2, c + 3, 3'd7});
      requester(2, 1'b0, 0, 31, 0);

      // Pacman and ghost requesting continuously for four accesses.
      tick();
      c = cyc;
`ifdef MAP_ARB_RR_EN
      q1.push_back('{1, c + 3, 3'd1});
      q1.push_back('{2, c + 7, 3'd7});
      q1.push_back('{1, c + 11, 3'd1});
      q1.push_back('{2, c + 15, 3'd7});
`else
      q1.push_back('{1, c + 3, 3'd1});
      q1.push_back('{1, c + 7, 3'd1});
      q1.push_back('{1, c + 11, 3'd1});
      q1.push_back('{1, c + 15, 3'd1});
`endif
      set_req(1, 1'b0, 10, 5, 0);
      set_req(2, 1'b0, 0, 31, 0);
      for (int k = 0; k < 16; k++) @(negedge clk);
      tick();
      clr_req(1);
      clr_req(2);
      repeat (6) tick();
      chk("stream_drained", q1.size(), 0);

      // Display drops its request during WAIT: RAM(31,0) = 7.
      tick();
      c = cyc;
      q1.push_back('{0, c + 3, 3'd7});
      set_req(0, 1'b0, 31, 0, 0);
      tick();
      tick();
      clr_req(0);
      wait_ack(0, 10);

      // Three-cycle latency instance: (4,9) -> 5 with early drop, (7,1) -> 6 held.
      tick();
      c = cyc;
      q3.push_back('{0, c + 5, 3'd5});
      set_req(3, 1'b0, 4, 9, 0);
      tick();
      tick();
      clr_req(3);
      wait_ack(3, 12);
      tick();
      tick();
      c = cyc;
      q3.push_back('{0, c + 5, 3'd6});
      requester(3, 1'b0, 7, 1, 0);

      repeat (8) tick();
      chk("q1_empty", q1.size(), 0);
      chk("q3_empty", q3.size(), 0);
      chk("d3_no_write", d3_wr_cnt, 0);
      chk("d3_idle", 32'({d3_busy, d3_pac_rdata, d3_ghost_rdata, d3_map_data_in}), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
